// File: rtl/signed_seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default width and the sign-magnitude helper used at operand capture.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam logic [DIV_MAX_W:0] ONE_EXT = {{DIV_MAX_W{1'b0}}, 1'b1};

  // Magnitude of a sign-extended value, kept in width+1 bits so -2^(width-1) survives.
  function automatic logic [DIV_MAX_W:0] abs_ext(input logic [DIV_MAX_W-1:0] value,
                                                 input int width);
    logic [DIV_MAX_W:0] ext;
    logic [DIV_MAX_W:0] mask;
    ext  = {value[DIV_MAX_W-1], value};
    mask = (ONE_EXT << (width + 1)) - ONE_EXT;
    if (ext[DIV_MAX_W]) begin
      abs_ext = (~ext + ONE_EXT) & mask;
    end else begin
      abs_ext = ext & mask;
    end
  endfunction

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One restoring shift-subtract iteration on the packed {R,Q} pair.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] rq_in,
  input  logic [WIDTH:0]     dmag,
  output logic [2*WIDTH-1:0] rq_out
);

  logic [2*WIDTH:0] sh_s;
  logic [WIDTH:0]   trial_s;

  assign sh_s    = {rq_in, 1'b0};
  assign trial_s = sh_s[2*WIDTH:WIDTH] - dmag;

  // Keep the trial difference when it is non-negative, otherwise restore.
  always_comb begin
    rq_out = sh_s[2*WIDTH-1:0];
    if (!trial_s[WIDTH]) begin
      rq_out = {trial_s[WIDTH-1:0], sh_s[WIDTH-1:1], 1'b1};
    end else begin
      rq_out = sh_s[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle truncating signed divider: unsigned restoring core on operand
// magnitudes, with signs re-applied in a single fix-up cycle.
module signed_seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0]       S_IDLE    = IDLE;
  localparam logic [1:0]       S_RUN     = RUN;
  localparam logic [1:0]       S_FIX     = FIX;
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] rq_r;
  logic [2*WIDTH-1:0] rq_next_s;
  logic [WIDTH:0]     dmag_r;
  logic [WIDTH-1:0]   dvd_mag_s;
  logic [WIDTH:0]     dsr_mag_s;
  logic [WIDTH-1:0]   q_mag_s;
  logic [WIDTH-1:0]   r_mag_s;
  logic               q_neg_r;
  logic               r_neg_r;
  logic               zero_r;
  logic               ovf_r;

  // The dividend magnitude (at most 2^(WIDTH-1)) always fits the WIDTH-bit Q field.
  assign dvd_mag_s = WIDTH'(abs_ext(DIV_MAX_W'($signed(dividend)), WIDTH));
  assign dsr_mag_s = (WIDTH + 1)'(abs_ext(DIV_MAX_W'($signed(divisor)), WIDTH));
  assign q_mag_s   = rq_r[WIDTH-1:0];
  assign r_mag_s   = rq_r[2*WIDTH-1:WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq_in (rq_r),
    .dmag  (dmag_r),
    .rq_out(rq_next_s)
  );

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rq_r        <= {(2*WIDTH){1'b0}};
      dmag_r      <= {(WIDTH+1){1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= ALL_ZERO;
      remainder   <= ALL_ZERO;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // A start coinciding with the done pulse is deliberately refused.
          if (start && !done) begin
            q_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
            ovf_r   <= (dividend == MOST_NEG) && (divisor == ALL_ONES);
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            if (divisor == ALL_ZERO) begin
              zero_r  <= 1'b1;
              rq_r    <= {ALL_ZERO, dividend};
              dmag_r  <= {(WIDTH+1){1'b0}};
              state_r <= S_FIX;
            end else begin
              zero_r  <= 1'b0;
              rq_r    <= {ALL_ZERO, dvd_mag_s};
              dmag_r  <= dsr_mag_s;
              state_r <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rq_r  <= rq_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= zero_r;
          overflow    <= ovf_r && !zero_r;
          if (zero_r) begin
            quotient  <= ALL_ONES;
            remainder <= q_mag_s;
          end else begin
            quotient  <= q_neg_r ? -q_mag_s : q_mag_s;
            remainder <= r_neg_r ? -r_mag_s : r_mag_s;
          end
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Randomised and directed bench for signed_seq_divider against a plain
// integer-arithmetic reference model.
module tb_signed_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_total = 0;
  int n_bad   = 0;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating division in 64-bit arithmetic; the quotient of -2^31/-1 wraps on truncation.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output logic o);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 64'sd0) begin
      q = {W{1'b1}};
      r = a;
      z = 1'b1;
      o = 1'b0;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
      z  = 1'b0;
      o  = (lq == (64'sd1 <<< (W - 1)));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".q"}, 64'(quotient), 64'd0);
    check({tag, ".r"}, 64'(remainder), 64'd0);
    check({tag, ".dz"}, 64'(div_by_zero), 64'd0);
    check({tag, ".ov"}, 64'(overflow), 64'd0);
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    logic [W-1:0] eq, er;
    logic ez, eo;
    int lat, busy_bad;
    ref_div(a, b, eq, er, ez, eo);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_bad = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat >= 1 && busy !== 1'b1) busy_bad++;
      if (scramble) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    check($sformatf("lat %0h/%0h", a, b), 64'(lat), (b == {W{1'b0}}) ? 64'd1 : 64'(W + 1));
    check("busy_run", 64'(busy_bad), 64'd0);
    check("busy_at_done", 64'(busy), 64'd0);
    check($sformatf("q %0h/%0h", a, b), 64'(quotient), 64'(eq));
    check($sformatf("r %0h/%0h", a, b), 64'(remainder), 64'(er));
    check("dz", 64'(div_by_zero), 64'(ez));
    check("ov", 64'(overflow), 64'(eo));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("q_held", 64'(quotient), 64'(eq));
  endtask

  logic [W-1:0] ra, rb, got_q, got_r;
  int dones, first_lat;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = {W{1'b0}};
    divisor  = {W{1'b0}};
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    run_div(32'd7, 32'd2, 1'b0);
    run_div(-32'sd7, 32'd2, 1'b1);
    run_div(32'd7, -32'sd2, 1'b0);
    run_div(-32'sd7, -32'sd2, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(-32'sd79815, 32'd255, 1'b0);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'd9, 32'd3, 1'b0);

    // Extra starts mid-operation and one during the done cycle must all be ignored.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    dividend  = 32'd1;
    divisor   = 32'd1;
    dones     = 0;
    first_lat = 0;
    got_q     = {W{1'b0}};
    got_r     = {W{1'b0}};
    for (int c = 0; c < 80; c++) begin
      start = (c == 5 || c == 20 || done === 1'b1);
      if (done === 1'b1) begin
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          first_lat = c + 1;
          got_q     = quotient;
          got_r     = remainder;
        end
      end
    end
    start = 1'b0;
    check("hs_dones", 64'(dones), 64'd1);
    check("hs_lat", 64'(first_lat), 64'(W + 1));
    check("hs_q", 64'(got_q), 64'd14);
    check("hs_r", 64'(got_r), 64'd2);
    check("hs_idle", 64'(busy), 64'd0);

    // Reset part-way through an operation aborts it without a done.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("midreset");
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("midreset_nodone", 64'(dones), 64'd0);
    run_div(32'd100, 32'd7, 1'b0);

    // Reset has priority over a simultaneous start.
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check_cleared("rst_start");
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = W'($signed(32'($urandom_range(0, 20)) - 32'd10));
        1: rb = {W{1'b0}};
        2: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd1; end
        3: ra = W'($signed(32'($urandom_range(0, 2000)) - 32'd1000));
        4: rb = 32'h8000_0000;
        default: rb = rb >> $urandom_range(0, 30);
      endcase
      run_div(ra, rb, i[0]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
